// File: rtl/line_memory_responder_pkg.sv
// rtl/line_memory_responder_pkg.sv - shared cache-line constants and responder state type
package line_memory_responder_pkg;

    localparam int LINE_WIDTH       = 256;
    localparam int LINE_BYTES       = 32;
    localparam int LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/line_memory_responder_mem_array.sv
// rtl/line_memory_responder_mem_array.sv - single-port line storage, synchronous write, registered read
module line_mem_array
    import line_memory_responder_pkg::*;
#(
    parameter int DEPTH    = 512,
    parameter int IDX_BITS = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_BITS-1:0]   idx,
    input  logic [LINE_WIDTH-1:0] wdata,
    output logic [LINE_WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; they are preloaded externally.
    logic [LINE_WIDTH-1:0] mem [DEPTH];

    // Commit a line write on the one-cycle write-enable pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read register holds its value between read pulses and clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - fixed-latency 256-bit line memory responder for the dcache
module line_memory_responder
    import line_memory_responder_pkg::*;
#(
    parameter int DEPTH            = 512,
    parameter int LATENCY          = 10,
    parameter int LINE_OFFSET_BITS = line_memory_responder_pkg::LINE_OFFSET_BITS
) (
    input  logic                  Clk_i,
    input  logic                  Rst_i,
    input  logic                  Enable_i,
    input  logic                  Write_i,
    input  logic [31:0]           Addr_i,
    input  logic [LINE_WIDTH-1:0] Data_i,
    output logic [LINE_WIDTH-1:0] Data_o,
    output logic                  Ack_o
);

    localparam int         IDX_BITS = $clog2(DEPTH);
    localparam logic [7:0] LAST     = 8'(LATENCY - 1);

    state_t                state;
    state_t                next_state;
    logic [7:0]            count;
    logic                  wr_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic [LINE_WIDTH-1:0] data_q;
    logic                  done;
    logic                  mem_we;
    logic                  mem_re;
    logic                  unused_addr;

    // Offset bits and aliasing upper bits take no part in line selection.
    assign unused_addr = ^{Addr_i[31:LINE_OFFSET_BITS+IDX_BITS], Addr_i[LINE_OFFSET_BITS-1:0]};

    // State register, latency counter, request latches and the registered ack.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state  <= IDLE;
            count  <= '0;
            wr_q   <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
            Ack_o  <= 1'b0;
        end else begin
            state <= next_state;
            Ack_o <= done;
            if (state == IDLE && Enable_i) begin
                wr_q   <= Write_i;
                idx_q  <= Addr_i[LINE_OFFSET_BITS +: IDX_BITS];
                data_q <= Data_i;
                count  <= '0;
            end else if (state == WAIT && !done) begin
                count <= count + 8'd1;
            end
        end
    end

    // Next-state decode; done marks the WAIT->ACK edge where storage is accessed.
    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (Enable_i) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (count == LAST) begin
                    done       = 1'b1;
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign mem_we = done & wr_q;
    assign mem_re = done & ~wr_q;

    line_mem_array #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) u_array (
        .clk   (Clk_i),
        .rst_n (Rst_i),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (idx_q),
        .wdata (data_q),
        .rdata (Data_o)
    );

endmodule

// File: tb/tb_line_memory_responder.sv
// tb/tb_line_memory_responder.sv - scoreboard bench for line_memory_responder
module tb_line_memory_responder;

    localparam int DEPTH   = 512;
    localparam int LATENCY = 10;

    typedef struct {
        bit           wr;
        int           idx;
        logic [255:0] data;
        int           ack_edge;
    } exp_t;

    logic         Clk_i = 1'b0;
    logic         Rst_i;
    logic         Enable_i;
    logic         Write_i;
    logic [31:0]  Addr_i;
    logic [255:0] Data_i;
    logic [255:0] Data_o;
    logic         Ack_o;

    exp_t         q[$];
    exp_t         tmp;
    logic [255:0] model_mem [DEPTH];
    logic [255:0] last_data = '0;
    int           edge_cnt  = -1;
    int           free_edge = 0;
    int           prev_ack  = -1;
    bit           b2b       = 1'b0;
    int           n_checks  = 0;
    int           n_fails   = 0;

    line_memory_responder #(
        .DEPTH            (DEPTH),
        .LATENCY          (LATENCY),
        .LINE_OFFSET_BITS (5)
    ) dut (
        .Clk_i    (Clk_i),
        .Rst_i    (Rst_i),
        .Enable_i (Enable_i),
        .Write_i  (Write_i),
        .Addr_i   (Addr_i),
        .Data_i   (Data_i),
        .Data_o   (Data_o),
        .Ack_o    (Ack_o)
    );

    always #5 Clk_i = ~Clk_i;

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a request is taken whenever Enable is seen while the
    // responder is free; it completes LATENCY edges later and frees two after.
    always @(posedge Clk_i) begin
        edge_cnt++;
        if (!Rst_i) begin
            free_edge = edge_cnt + 1;
        end else if (Enable_i && edge_cnt >= free_edge) begin
            tmp.wr       = Write_i;
            tmp.idx      = int'((Addr_i / 32) % DEPTH);
            tmp.data     = Write_i ? Data_i : model_mem[tmp.idx];
            tmp.ack_edge = edge_cnt + LATENCY;
            q.push_back(tmp);
            free_edge    = edge_cnt + LATENCY + 2;
        end
    end

    // Monitor: pop the scoreboard when an ack is due and compare outputs.
    always @(negedge Clk_i) begin
        if (!Rst_i) begin
            q.delete();
            last_data = '0;
        end else begin
            if (q.size() > 0 && q[0].ack_edge == edge_cnt) begin
                check("ack_due", 256'(Ack_o), 256'(1));
                if (q[0].wr) model_mem[q[0].idx] = q[0].data;
                else         last_data = q[0].data;
                if (b2b && prev_ack >= 0) check("ack_spacing", 256'(edge_cnt - prev_ack), 256'(LATENCY + 2));
                prev_ack = edge_cnt;
                void'(q.pop_front());
            end else begin
                check("ack_idle", 256'(Ack_o), 256'(0));
            end
            check("data_o", Data_o, last_data);
        end
    end

    task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] d, input bit perturb);
        int i;
        Enable_i = 1'b1;
        Write_i  = wr;
        Addr_i   = a;
        Data_i   = d;
        @(posedge Clk_i); #1;
        if (perturb) begin
            Addr_i = 32'h60;
            Data_i = rand_line();
        end
        for (i = 0; i < 100 && !Ack_o; i++) begin
            @(posedge Clk_i); #1;
        end
        if (!Ack_o) begin
            n_checks++;
            n_fails++;
            $display("FAIL txn_timeout: no ack for addr %h", a);
        end
        @(posedge Clk_i); #1;
        Enable_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] v;
        logic [31:0]  atab [4];
        Rst_i = 1'b0; Enable_i = 1'b0; Write_i = 1'b0; Addr_i = '0; Data_i = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = rand_line();
            model_mem[i] = v;
            dut.u_array.mem[i] = v;
        end
        v = {32{8'hA5}};
        model_mem[4] = v;
        dut.u_array.mem[4] = v;

        repeat (3) @(posedge Clk_i);
        #1 Rst_i = 1'b1;
        repeat (20) @(posedge Clk_i);
        #1;

        txn(1'b0, 32'h80, '0, 1'b0);
        txn(1'b1, 32'h40, 256'h1234, 1'b0);
        txn(1'b0, 32'h5F, rand_line(), 1'b0);
        txn(1'b0, 32'h60, '0, 1'b0);
        txn(1'b1, 32'h20, rand_line(), 1'b1);
        txn(1'b0, 32'h20, '0, 1'b0);
        txn(1'b0, 32'h60, '0, 1'b0);

        atab[0] = 32'h20; atab[1] = DEPTH * 32 + 32'h20; atab[2] = 32'h80; atab[3] = 32'hFFFF_FF9F;
        b2b = 1'b1;
        prev_ack = -1;
        Enable_i = 1'b1;
        for (int k = 0; k < 5 * (LATENCY + 2); k++) begin
            Write_i = 1'($urandom);
            Addr_i  = atab[k % 4];
            Data_i  = rand_line();
            @(posedge Clk_i); #1;
        end
        Enable_i = 1'b0;
        repeat (LATENCY + 3) @(posedge Clk_i);
        #1 b2b = 1'b0;
        txn(1'b0, DEPTH * 32 + 32'h20, '0, 1'b0);

        Enable_i = 1'b1; Write_i = 1'b1; Addr_i = 32'hE0; Data_i = rand_line();
        @(posedge Clk_i); #1;
        Enable_i = 1'b0;
        repeat (4) @(posedge Clk_i);
        #1 Rst_i = 1'b0;
        repeat (2) @(posedge Clk_i);
        #1 Rst_i = 1'b1;
        repeat (LATENCY + 3) @(posedge Clk_i);
        #1;
        txn(1'b0, 32'hE0, '0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            txn(1'($urandom), ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31)),
                rand_line(), 1'b0);
        end

        repeat (3) @(posedge Clk_i);
        #1;
        check("queue_drained", 256'(q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/line_memory_responder.md
Name: line_memory_responder

Overview:
- Responder end of the 256-bit cache-line memory interface that the data-cache controller drives as initiator (enable/write/addr/data out, data/ack in).
- Models main data memory with fixed, parameterised access latency.
- Accepts one line read or write at a time and answers each with a single-cycle ack.
- Instantiated in the testbench/top level beside the CPU, wired port-for-port to the CPU memory outputs.

Parameters:
- DEPTH, 512, number of 256-bit lines stored; power of two.
- LATENCY, 10, clock edges from request acceptance to Ack_o assertion; legal range 1..255.
- LINE_OFFSET_BITS, 5, byte-offset bits ignored in Addr_i (32-byte lines).

Ports:
- Clk_i  in  1  clock, all state updates on rising edge.
- Rst_i  in  1  reset, asynchronous, active-low.
- Enable_i  in  1  request valid from initiator.
- Write_i  in  1  1 = line write, 0 = line read; sampled with Enable_i.
- Addr_i  in  32  byte address of line.
- Data_i  in  256  write line data.
- Data_o  out  256  read line data, registered.
- Ack_o  out  1  completion pulse, registered.

Behaviour:
- Reset (Rst_i low, asynchronous): state IDLE, counter 0, Ack_o 0, Data_o 0, request latches cleared. The storage array is not cleared; its contents are preloaded by the bench.
- Line index = Addr_i[LINE_OFFSET_BITS +: log2(DEPTH)]. Upper address bits are ignored, so addresses alias modulo DEPTH lines. Addr_i[4:0] are ignored.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If Enable_i = 1 at the edge, latch Write_i, line index and Data_i; counter <= 0; go to WAIT. This edge is the acceptance edge E0.
  - Otherwise stay in IDLE.
- WAIT:
  - If counter == LATENCY-1, go to ACK. Otherwise counter <= counter+1.
  - Enable_i, Addr_i, Write_i and Data_i are ignored. The latched copies are used, so later input changes do not matter.
- At the WAIT->ACK edge (edge E0+LATENCY):
  - Latched write: array[index] <= latched data. Data_o is unchanged.
  - Latched read: Data_o <= array[index].
- ACK:
  - Ack_o = 1 for exactly this one cycle.
  - Unconditionally go to IDLE at the next edge. Enable_i sampled in the ACK cycle is ignored.
- Protocol rule: the initiator deasserts Enable_i in the cycle after it sees Ack_o. If Enable_i is still high in that following IDLE cycle, it is a new request by definition.
- Latency: Ack_o is high in the cycle following edge E0+LATENCY. With LATENCY = 10, a request sampled at edge 0 gives Ack_o high after edge 10. The minimum request-to-request spacing is LATENCY+2 cycles.
- Data_o is held between read acks. It is valid to the initiator only in the ACK cycle.
- Read-after-write to the same line returns the written data, because the write has committed by the write's ACK cycle.
- Reset mid-transaction aborts it: no array write, no Ack_o, state IDLE.
- Ack_o and Data_o are pure register outputs, with no combinational path from inputs.

Decomposition:
- Shared package:
  - state enum {IDLE, WAIT, ACK};
  - LINE_WIDTH = 256;
  - LINE_BYTES = 32;
  - LINE_OFFSET_BITS = 5.
- The dcache controller uses the same LINE_WIDTH and LINE_OFFSET_BITS constants.
- One natural sub-module: line_mem_array, a single-port DEPTH x 256 synchronous-write / registered-read storage that the FSM drives with a one-cycle write-enable or read-enable pulse at the WAIT->ACK edge.

Test Plan:
- Reset then idle: Rst_i low for 3 cycles, Enable_i 0 for 20 cycles -> Ack_o and Data_o stay 0, state IDLE.
- Read latency (LATENCY = 10): preload line 4 with 256'hA5..A5; Enable_i = 1, Write_i = 0, Addr_i = 32'h80 at edge 0, deasserted after ack -> Ack_o high only in the cycle after edge 10, Data_o = 256'hA5..A5 in that cycle.
- Write then read: write 256'h1234 to Addr_i = 32'h40, then read 32'h5F (same line, offset ignored) -> second ack returns 256'h1234; no other line changes.
- Inputs change during WAIT: accept a write to 32'h20 with data X, then change Addr_i/Data_i to 32'h60/Y during WAIT -> line 1 = X, line 3 unchanged.
- Back-to-back: Enable_i held continuously high, alternating addresses -> ack pulses exactly LATENCY+2 cycles apart, never in consecutive cycles. Aliasing: Addr_i = DEPTH*32 + 32'h20 with DEPTH = 512 accesses line 1.
- Reset mid-write: accept a write to line 7 with new data, assert Rst_i at edge 5 -> no Ack_o, line 7 keeps its old value, and the next read of line 7 returns the old data.
